// File: rtl/bus_fifo_arbiter_if.sv
// Handshake bundle between bus_fifo_arbiter, its per-lane FIFOs and the downstream bus consumer.
// master: the arbiter side; slave: the FIFO/consumer side.
interface bus_fifo_arbiter_if #(
   parameter int NUM_REQ  = 4,
   parameter int DATA_LEN = 16,
   parameter int ID_LEN   = $clog2(NUM_REQ)
);
   logic [NUM_REQ-1:0]          fifo_wr_en;
   logic [NUM_REQ-1:0]          fifo_rd_en;
   logic [NUM_REQ*DATA_LEN-1:0] fifo_rd_data;
   logic                        bus_ready;
   logic                        bus_valid;
   logic [DATA_LEN-1:0]         bus_data;
   logic [ID_LEN-1:0]           bus_src;
   logic                        grant_busy;
   logic                        err_overflow;

   modport master (
      input  fifo_wr_en, fifo_rd_data, bus_ready,
      output fifo_rd_en, bus_valid, bus_data, bus_src, grant_busy, err_overflow
   );

   modport slave (
      output fifo_wr_en, fifo_rd_data, bus_ready,
      input  fifo_rd_en, bus_valid, bus_data, bus_src, grant_busy, err_overflow
   );
endinterface

// File: rtl/bus_fifo_arbiter.sv
// Round-robin drain of NUM_REQ bus FIFOs onto one shared bus with bounded bursts per grant.
// Optional macro BUS_ARB_PRIO0_EN: FIFO 0 wins every arbitration while it holds data.
module bus_fifo_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_LEN  = 16,
   parameter int DEPTH     = 64,
   parameter int ADDR_LEN  = $clog2(DEPTH),
   parameter int ID_LEN    = $clog2(NUM_REQ),
   parameter int MAX_BURST = 8
) (
   input  logic               clk,
   input  logic               rstn,
   bus_fifo_arbiter_if.master bif
);
   localparam int BURST_LEN = $clog2(MAX_BURST + 1);
   localparam logic [ADDR_LEN-1:0]  CNT_FULL   = ADDR_LEN'(DEPTH - 1);
   localparam logic [BURST_LEN-1:0] BURST_MAX  = BURST_LEN'(MAX_BURST);
   localparam logic [BURST_LEN-1:0] BURST_LAST = BURST_LEN'(MAX_BURST - 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t               state_q, state_d;
   logic [ADDR_LEN-1:0]  count_q [NUM_REQ];
   logic [NUM_REQ-1:0]   nonempty;
   logic [ID_LEN-1:0]    rr_ptr_q, rr_ptr_d;
   logic [ID_LEN-1:0]    grant_q, grant_d;
   logic [BURST_LEN-1:0] burst_cnt_q, burst_cnt_d;
   logic                 hit;
   logic [ID_LEN-1:0]    hit_idx;
   logic                 rd_ok;
   logic                 last_word;
   logic [NUM_REQ-1:0]   rd_en;
   logic                 bus_valid_q;
   logic [ID_LEN-1:0]    bus_src_q;
   logic                 err_q;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) nonempty[i] = (count_q[i] != '0);
   end

   // Shadow occupancy: the FIFO empty flags lag a cycle, so these counts gate every read.
   // NOTE: the count array is reset explicitly; arbitration inspects every entry straight out of reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < NUM_REQ; i++) count_q[i] <= '0;
         err_q <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (bif.fifo_wr_en[i] && !rd_en[i]) begin
               if (count_q[i] == CNT_FULL) err_q <= 1'b1;
               else                        count_q[i] <= count_q[i] + ADDR_LEN'(1);
            end else if (!bif.fifo_wr_en[i] && rd_en[i]) begin
               count_q[i] <= count_q[i] - ADDR_LEN'(1);
            end
         end
      end
   end

   assign rd_ok     = (state_q == GRANT) && bif.bus_ready && nonempty[grant_q] &&
                      (burst_cnt_q < BURST_MAX);
   assign rd_en     = rd_ok ? (NUM_REQ'(1) << grant_q) : '0;
   assign last_word = (count_q[grant_q] == ADDR_LEN'(1)) && !bif.fifo_wr_en[grant_q];

   // First non-empty FIFO after the last grant, wrapping modulo NUM_REQ.
   always_comb begin
      int cand;
      hit     = 1'b0;
      hit_idx = '0;
      cand    = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = (int'(rr_ptr_q) + k) % NUM_REQ;
         if (!hit && nonempty[cand]) begin
            hit     = 1'b1;
            hit_idx = ID_LEN'(cand);
         end
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      rr_ptr_d    = rr_ptr_q;
      burst_cnt_d = burst_cnt_q;
      case (state_q)
         IDLE: begin
`ifdef BUS_ARB_PRIO0_EN
            if (nonempty[0]) begin
               state_d     = GRANT;
               grant_d     = '0;
               burst_cnt_d = '0;
            end else
`endif
            if (hit) begin
               state_d     = GRANT;
               grant_d     = hit_idx;
               rr_ptr_d    = hit_idx;
               burst_cnt_d = '0;
            end
         end
         GRANT: begin
            if (rd_ok) begin
               burst_cnt_d = burst_cnt_q + BURST_LEN'(1);
               if ((burst_cnt_q == BURST_LAST) || last_word) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops sample the same pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         rr_ptr_q    <= ID_LEN'(NUM_REQ - 1);
         burst_cnt_q <= '0;
         bus_valid_q <= 1'b0;
         bus_src_q   <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         rr_ptr_q    <= rr_ptr_d;
         burst_cnt_q <= burst_cnt_d;
         bus_valid_q <= |rd_en;
         bus_src_q   <= grant_q;
      end
   end

   assign bif.fifo_rd_en   = rd_en;
   assign bif.bus_valid    = bus_valid_q;
   assign bif.bus_src      = bus_src_q;
   assign bif.bus_data     = bif.fifo_rd_data[int'(bus_src_q) * DATA_LEN +: DATA_LEN];
   assign bif.grant_busy   = (state_q == GRANT);
   assign bif.err_overflow = err_q;
endmodule

// File: tb/tb_bus_fifo_arbiter.sv
// Bench for bus_fifo_arbiter: queue-based FIFO models, a word scoreboard, directed scenarios and random traffic.
// Expected schedules come from burst/rotation arithmetic; BUS_ARB_PRIO0_EN selects the priority ordering.
module tb_bus_fifo_arbiter;
   localparam int NUM_REQ   = 4;
   localparam int DATA_LEN  = 16;
   localparam int DEPTH     = 64;
   localparam int ID_LEN    = 2;
   localparam int MAX_BURST = 8;

   typedef logic [DATA_LEN-1:0] word_t;

   logic  clk  = 1'b0;
   logic  rstn = 1'b0;
   word_t wr_data [NUM_REQ];
   word_t rd_reg  [NUM_REQ];
   word_t fq      [NUM_REQ][$];
   word_t exp_q   [NUM_REQ][$];
   int    src_log [$];
   int    n_assert = 0;
   int    n_fail   = 0;

   always #5 clk = ~clk;

   bus_fifo_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_LEN(DATA_LEN), .ID_LEN(ID_LEN)) bif ();

   bus_fifo_arbiter #(
      .NUM_REQ(NUM_REQ), .DATA_LEN(DATA_LEN), .DEPTH(DEPTH),
      .ID_LEN(ID_LEN), .MAX_BURST(MAX_BURST)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bif  (bif.master)
   );

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_rd
      assign bif.fifo_rd_data[g*DATA_LEN +: DATA_LEN] = rd_reg[g];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   function automatic int pending();
      int n = 0;
      for (int i = 0; i < NUM_REQ; i++) n += exp_q[i].size();
      return n;
   endfunction

   // Behavioural FIFOs: registered rd_data valid the cycle after rd_en, cleared by the shared reset.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            fq[i].delete();
            exp_q[i].delete();
            rd_reg[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (bif.fifo_rd_en[i] && fq[i].size() > 0) rd_reg[i] <= fq[i].pop_front();
            if (bif.fifo_wr_en[i] && fq[i].size() < DEPTH) begin
               fq[i].push_back(wr_data[i]);
               exp_q[i].push_back(wr_data[i]);
            end
         end
      end
   end

   // Bus monitor: strobe legality, no over-read, and per-source in-order data integrity.
   always @(negedge clk) begin
      #2;
      if (rstn) begin
         check("rd_en_onehot0", 32'($onehot0(bif.fifo_rd_en)), 32'd1);
         for (int i = 0; i < NUM_REQ; i++)
            if (bif.fifo_rd_en[i]) check("rd_nonempty", 32'(fq[i].size() > 0), 32'd1);
         if (bif.bus_valid) begin
            src_log.push_back(int'(bif.bus_src));
            check("bus_word_pending", 32'(exp_q[bif.bus_src].size() > 0), 32'd1);
            if (exp_q[bif.bus_src].size() > 0)
               check("bus_data", 32'(bif.bus_data), 32'(exp_q[bif.bus_src].pop_front()));
         end
      end
   end

   task automatic step(input logic [NUM_REQ-1:0] wr, input logic rdy);
      @(negedge clk);
      bif.fifo_wr_en = wr;
      bif.bus_ready  = rdy;
      for (int i = 0; i < NUM_REQ; i++) wr_data[i] = DATA_LEN'($urandom);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn           = 1'b0;
      bif.fifo_wr_en = '0;
      bif.bus_ready  = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      src_log.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rd_en"}, 32'(bif.fifo_rd_en), 32'd0);
      check({tag, "_valid"}, 32'(bif.bus_valid), 32'd0);
      check({tag, "_src"},   32'(bif.bus_src), 32'd0);
      check({tag, "_busy"},  32'(bif.grant_busy), 32'd0);
      check({tag, "_err"},   32'(bif.err_overflow), 32'd0);
   endtask

   initial begin
      int exp_rd [$];
      int exp_src [$];
      int rem, n_rd, n_wr;
      logic [NUM_REQ-1:0] wr;

      bif.fifo_wr_en = '0;
      bif.bus_ready  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) wr_data[i] = '0;
      repeat (2) @(negedge clk);
      #1;
      check_reset_outputs("reset");
      rstn = 1'b1;

      // Single word 0xA5A5 into FIFO 2: rd_en in cycle 2, bus word in cycle 3.
      step(4'b0100, 1'b1);
      wr_data[2] = 16'hA5A5;
      check("single_c0_rd", 32'(bif.fifo_rd_en), 32'd0);
      step('0, 1'b1);
      check("single_c1_rd", 32'(bif.fifo_rd_en), 32'd0);
      check("single_c1_busy", 32'(bif.grant_busy), 32'd0);
      step('0, 1'b1);
      check("single_c2_rd", 32'(bif.fifo_rd_en), 32'b0100);
      check("single_c2_busy", 32'(bif.grant_busy), 32'd1);
      step('0, 1'b1);
      check("single_c3_valid", 32'(bif.bus_valid), 32'd1);
      check("single_c3_data", 32'(bif.bus_data), 32'hA5A5);
      check("single_c3_src", 32'(bif.bus_src), 32'd2);
      check("single_c3_busy", 32'(bif.grant_busy), 32'd0);
      step('0, 1'b1);
      check("single_c4_valid", 32'(bif.bus_valid), 32'd0);
      check("single_c4_rd", 32'(bif.fifo_rd_en), 32'd0);

      // Burst cap: 20 words in FIFO 0 drain as runs of MAX_BURST separated by one bubble.
      do_reset();
      repeat (20) step(4'b0001, 1'b0);
      exp_rd.delete();
      rem = 20;
      while (rem > 0) begin
         for (int k = 0; k < ((rem < MAX_BURST) ? rem : MAX_BURST); k++) exp_rd.push_back(1);
         rem -= (rem < MAX_BURST) ? rem : MAX_BURST;
         if (rem > 0) exp_rd.push_back(0);
      end
      repeat (4) exp_rd.push_back(0);
      foreach (exp_rd[k]) begin
         step('0, 1'b1);
         check("burst_rd_en", 32'(bif.fifo_rd_en), 32'(exp_rd[k]));
      end
      check("burst_words", 32'(src_log.size()), 32'd20);

      // Rotation: 3 words in each FIFO, rr_ptr starts at NUM_REQ-1 so FIFO 0 goes first.
      do_reset();
      repeat (3) step(4'b1111, 1'b0);
      exp_rd.delete();
      exp_src.delete();
      for (int s = 0; s < NUM_REQ; s++) begin
         repeat (3) begin
            exp_rd.push_back(1 << s);
            exp_src.push_back(s);
         end
         exp_rd.push_back(0);
      end
      repeat (3) exp_rd.push_back(0);
      foreach (exp_rd[k]) begin
         step('0, 1'b1);
         check("rot_rd_en", 32'(bif.fifo_rd_en), 32'(exp_rd[k]));
      end
      check("rot_words", 32'(src_log.size()), 32'(exp_src.size()));
      foreach (exp_src[k])
         if (k < src_log.size()) check("rot_src", 32'(src_log[k]), 32'(exp_src[k]));
      // Last grant was 3, so FIFO 1 must beat FIFO 3.
      step(4'b1010, 1'b1);
      step('0, 1'b1);
      step('0, 1'b1);
      check("rot_ptr_first", 32'(bif.fifo_rd_en), 32'b0010);
      step('0, 1'b1);
      step('0, 1'b1);
      check("rot_ptr_second", 32'(bif.fifo_rd_en), 32'b1000);

      // Backpressure: 5 words into FIFO 1, bus_ready low in cycles 4..9.
      do_reset();
      n_rd = 0;
      for (int c = 0; c < 16; c++) begin
         step((c <= 4) ? 4'b0010 : 4'b0000, !(c >= 4 && c <= 9));
         if (!(c >= 4 && c <= 9) && c >= 2 && n_rd < 5) begin
            check("bp_rd_en", 32'(bif.fifo_rd_en), 32'b0010);
            n_rd++;
         end else begin
            check("bp_no_rd", 32'(bif.fifo_rd_en), 32'd0);
         end
         if (c >= 4 && c <= 9) check("bp_busy", 32'(bif.grant_busy), 32'd1);
      end
      check("bp_words", 32'(src_log.size()), 32'd5);

      // Concurrent write/read on FIFO 3: streams MAX_BURST reads, bubbles, then re-grants.
      do_reset();
      for (int c = 0; c <= 12; c++) begin
         step((c == 1) ? 4'b0000 : 4'b1000, 1'b1);
         check("conc_rd_en", 32'(bif.fifo_rd_en),
               ((c >= 2 && c <= 9) || c >= 11) ? 32'b1000 : 32'd0);
      end
      for (int c = 0; c < 40 && (pending() > 0 || bif.bus_valid); c++) step('0, 1'b1);
      check("conc_drained", 32'(pending()), 32'd0);
      check("conc_err", 32'(bif.err_overflow), 32'd0);

      // Overflow: 64th write into FIFO 1 with no reads sets the sticky flag.
      do_reset();
      for (int c = 0; c < 64; c++) step(4'b0010, 1'b0);
      check("ovf_before", 32'(bif.err_overflow), 32'd0);
      step('0, 1'b0);
      check("ovf_set", 32'(bif.err_overflow), 32'd1);
      repeat (4) step('0, 1'b1);
      check("ovf_midburst_valid", 32'(bif.bus_valid), 32'd1);
      #2;
      rstn = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      @(negedge clk);
      rstn = 1'b1;
      for (int c = 0; c < 10; c++) begin
         step('0, 1'b1);
         check("post_reset_rd", 32'(bif.fifo_rd_en), 32'd0);
         check("post_reset_valid", 32'(bif.bus_valid), 32'd0);
      end

      // FIFO 0 with 10 words against FIFO 2 with 3 words.
      do_reset();
      for (int c = 0; c < 10; c++) step(4'b0001 | ((c < 3) ? 4'b0100 : 4'b0000), 1'b0);
      for (int c = 0; c < 25; c++) step('0, 1'b1);
      exp_src.delete();
`ifdef BUS_ARB_PRIO0_EN
      repeat (10) exp_src.push_back(0);
      repeat (3)  exp_src.push_back(2);
`else
      repeat (MAX_BURST)      exp_src.push_back(0);
      repeat (3)              exp_src.push_back(2);
      repeat (10 - MAX_BURST) exp_src.push_back(0);
`endif
      check("arb_words", 32'(src_log.size()), 32'(exp_src.size()));
      foreach (exp_src[k])
         if (k < src_log.size()) check("arb_src", 32'(src_log[k]), 32'(exp_src[k]));

      // Random traffic with random backpressure, then a bounded drain.
      do_reset();
      n_wr = 0;
      for (int c = 0; c < 3000; c++) begin
         wr = '0;
         for (int i = 0; i < NUM_REQ; i++)
            if ($urandom_range(0, 9) < 3 && exp_q[i].size() < DEPTH - 8) begin
               wr[i] = 1'b1;
               n_wr++;
            end
         step(wr, $urandom_range(0, 3) != 0);
      end
      for (int c = 0; c < 2000 && (pending() > 0 || bif.bus_valid); c++) step('0, 1'b1);
      step('0, 1'b1);
      check("rand_drained", 32'(pending()), 32'd0);
      check("rand_delivered", 32'(src_log.size()), 32'(n_wr));
      check("rand_err", 32'(bif.err_overflow), 32'd0);
      check("rand_idle", 32'(bif.grant_busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
